// File: rtl/song_writer_pkg.sv
// Shared song-memory definitions: field widths, word layout and writer FSM encodings.
// The TERM state exists only when SONG_WRITER_TERMINATOR_EN is defined.
package song_writer_pkg;

  localparam int SONG_WIDTH     = 5;   // word index bits within one song slot
  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int SONG_WORDS     = 32;

  localparam int WORD_W   = 16;
  localparam int ADV_BIT  = 15;
  localparam int NOTE_LSB = 9;
  localparam int DUR_LSB  = 3;

  localparam logic [NOTE_WIDTH-1:0] GAP_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    WR_ADV  = 3'd3,
    WR_NOTE = 3'd4,
    FULL    = 3'd5
`ifdef SONG_WRITER_TERMINATOR_EN
    , TERM  = 3'd6
`endif
  } state_t;

  // Advance words carry the gap in the note field and zero in the duration field.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic                      adv,
    input logic [NOTE_WIDTH-1:0]     hi,
    input logic [DURATION_WIDTH-1:0] lo
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[ADV_BIT] = adv;
    w[NOTE_LSB +: NOTE_WIDTH] = hi;
    w[DUR_LSB +: DURATION_WIDTH] = lo;
    return w;
  endfunction

endpackage

// File: rtl/song_writer_gap.sv
// Beat gap counter for the song writer: a saturating beat count held in a dffr register.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

module beat_gap_counter
  import song_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  beat,
  output logic [NOTE_WIDTH-1:0] gap
);

  logic [NOTE_WIDTH-1:0] gap_d;

  function automatic logic [NOTE_WIDTH-1:0] sat_inc(input logic [NOTE_WIDTH-1:0] v);
    return (v == GAP_MAX) ? v : v + 1'b1;
  endfunction

  // A clear restarts the count, but a beat in the same cycle already belongs to the new gap.
  always_comb begin
    gap_d = gap;
    if (clr)              gap_d = {{(NOTE_WIDTH-1){1'b0}}, beat};
    else if (en && beat)  gap_d = sat_inc(gap);
  end

  dffr #(.W(NOTE_WIDTH)) u_gap_q (
    .clk   (clk),
    .reset (reset),
    .d     (gap_d),
    .q     (gap)
  );

endmodule

// File: rtl/song_writer.sv
// Records note events into a song RAM slot as note and gap-advance words.
// Define SONG_WRITER_TERMINATOR_EN to append a zero terminator word when recording stops.
module song_writer
  import song_writer_pkg::*;
#(
  parameter int NOTE_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic [1:0]        song,
  input  logic              new_note,
  input  logic [NOTE_W-1:0] note,
  input  logic [NOTE_W-1:0] duration,
  input  logic              beat,
  output logic              note_ready,
  output logic              wr_en,
  output logic [6:0]        wr_addr,
  output logic [15:0]       wr_data,
  output logic              recording,
  output logic              song_full,
  output logic [5:0]        words_written
);

  localparam logic [SONG_WIDTH-1:0] IDX_LAST = '1;

`ifdef SONG_WRITER_TERMINATOR_EN
  localparam state_t STOP_ST = TERM;
`else
  localparam state_t STOP_ST = IDLE;
`endif

  state_t                    state, state_nx;
  logic                      record_q;
  logic [1:0]                song_q;
  logic [SONG_WIDTH-1:0]     idx;
  logic [NOTE_WIDTH-1:0]     note_q, gap_q, gap_cnt;
  logic [DURATION_WIDTH-1:0] dur_q;
  logic                      start, accept, gap_en, gap_beat;

  function automatic logic [5:0] ww_inc(input logic [5:0] v);
    return (v >= 6'(SONG_WORDS)) ? v : v + 6'd1;
  endfunction

  assign start     = (state == IDLE) && record && !record_q;
  assign accept    = note_ready && new_note;
  assign recording = (state != IDLE);
  assign wr_addr   = {song_q, idx};
  assign gap_en    = (state == CAPTURE) || (state == WR_ADV) || (state == WR_NOTE);
  assign gap_beat  = beat && !start;

  beat_gap_counter u_gap (
    .clk   (clk),
    .reset (reset),
    .en    (gap_en),
    .clr   (accept || start),
    .beat  (gap_beat),
    .gap   (gap_cnt)
  );

  always_comb begin
    state_nx   = state;
    note_ready = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    case (state)
      IDLE: if (start) state_nx = ARMED;
      ARMED: begin
        note_ready = 1'b1;
        if (new_note)     state_nx = WR_NOTE;
        else if (!record) state_nx = STOP_ST;
      end
      CAPTURE: begin
        note_ready = 1'b1;
        if (new_note)     state_nx = (gap_cnt != '0) ? WR_ADV : WR_NOTE;
        else if (!record) state_nx = STOP_ST;
      end
      WR_ADV: begin
        wr_en    = 1'b1;
        wr_data  = pack_word(1'b1, gap_q, '0);
        state_nx = (idx == IDX_LAST) ? FULL : WR_NOTE;
      end
      // The pair always finishes; a dropped record is only honoured after the note word.
      WR_NOTE: begin
        wr_en   = 1'b1;
        wr_data = pack_word(1'b0, note_q, dur_q);
        if (idx == IDX_LAST) state_nx = FULL;
        else if (record)     state_nx = CAPTURE;
        else                 state_nx = STOP_ST;
      end
      FULL: if (!record) state_nx = IDLE;
`ifdef SONG_WRITER_TERMINATOR_EN
      TERM: begin
        wr_en    = (words_written < 6'(SONG_WORDS));
        state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      record_q      <= 1'b0;
      song_q        <= '0;
      idx           <= '0;
      note_q        <= '0;
      dur_q         <= '0;
      gap_q         <= '0;
      song_full     <= 1'b0;
      words_written <= '0;
    end else begin
      state    <= state_nx;
      record_q <= record;
      if (start) begin
        song_q        <= song;
        idx           <= '0;
        words_written <= '0;
        song_full     <= 1'b0;
      end else begin
        if (wr_en) begin
          idx           <= idx + 1'b1;
          words_written <= ww_inc(words_written);
        end
        if (state_nx == FULL) song_full <= 1'b1;
      end
      if (accept) begin
        note_q <= NOTE_WIDTH'(note);
        dur_q  <= DURATION_WIDTH'(duration);
        gap_q  <= gap_cnt;
      end
    end
  end

endmodule
